// File: rtl/y86_fetch_decode_queue_if.sv
// Fetch-beat and decoded-instruction handshake bundle for the Y86-64 fetch/decode queue.
// master = fetch/execute environment, slave = the queue itself.
interface y86_fetch_decode_queue_if #(
    parameter int BYTES_PER_BEAT = 8,
    parameter int PC_W           = 64
);
    logic                          in_valid;
    logic                          in_ready;
    logic [8*BYTES_PER_BEAT-1:0]   in_data;
    logic                          in_err;
    logic                          redirect;
    logic [PC_W-1:0]               redirect_pc;
    logic                          out_valid;
    logic                          out_ready;
    logic [3:0]                    icode;
    logic [3:0]                    ifun;
    logic [3:0]                    rA;
    logic [3:0]                    rB;
    logic [63:0]                   valC;
    logic [PC_W-1:0]               pc;
    logic [PC_W-1:0]               valP;
    logic [1:0]                    stat;
    logic                          set_cc;
    logic [3:0]                    alufun;

    modport master (
        output in_valid, in_data, in_err, redirect, redirect_pc, out_ready,
        input  in_ready, out_valid, icode, ifun, rA, rB, valC, pc, valP, stat, set_cc, alufun
    );

    modport slave (
        input  in_valid, in_data, in_err, redirect, redirect_pc, out_ready,
        output in_ready, out_valid, icode, ifun, rA, rB, valC, pc, valP, stat, set_cc, alufun
    );
endinterface

// File: rtl/y86_fetch_decode_queue.sv
// Y86-64 fetch byte queue with head-of-queue variable-length decode.
// Beats are buffered per byte with an error flag; one instruction leaves per handshake.
module y86_fetch_decode_queue #(
    parameter int BYTES_PER_BEAT = 8,
    parameter int BUF_BYTES      = 32,
    parameter int PC_W           = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    y86_fetch_decode_queue_if.slave    bus
);
    localparam int AW = $clog2(BUF_BYTES);
    localparam int CW = AW + 1;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

    state_t                 state_r;
    logic [7:0]             mem_r [BUF_BYTES];
    logic [BUF_BYTES-1:0]   err_r;
    logic [AW-1:0]          rd_r;
    logic [AW-1:0]          wr_r;
    logic [CW-1:0]          count_r;
    logic [PC_W-1:0]        pc_r;

    logic [7:0]             hb_s [10];
    logic [9:0]             he_s;
    logic                   have_s;
    logic                   ok_s;
    logic                   regs_s;
    logic [1:0]             valc_mode_s;
    logic [3:0]             len_s;
    logic [63:0]            valc_s;
    logic                   err_hit_s;
    logic                   head_ready_s;
    logic [1:0]             stat_s;
    logic                   out_valid_s;
    logic                   in_ready_s;
    logic                   push_s;
    logic                   pop_s;
    logic [PC_W-1:0]        valp_s;

    // Window of the ten bytes (longest instruction) starting at the queue head.
    always_comb begin
        for (int i = 0; i < 10; i++) begin
            hb_s[i] = mem_r[rd_r + AW'(i)];
            he_s[i] = err_r[rd_r + AW'(i)];
        end
    end

    // Instruction length, field layout and validity from the head byte.
    always_comb begin
        regs_s      = 1'b0;
        valc_mode_s = 2'd0;
        len_s       = 4'd1;
        ok_s        = 1'b0;
        case (hb_s[0][7:4])
            4'h0, 4'h1, 4'h9: begin
                ok_s = (hb_s[0][3:0] == 4'h0);
            end
            4'h2: begin
                len_s = 4'd2; regs_s = 1'b1; ok_s = (hb_s[0][3:0] <= 4'h6);
            end
            4'h6: begin
                len_s = 4'd2; regs_s = 1'b1; ok_s = (hb_s[0][3:0] <= 4'h3);
            end
            4'hA, 4'hB: begin
                len_s = 4'd2; regs_s = 1'b1; ok_s = (hb_s[0][3:0] == 4'h0);
            end
            4'h7: begin
                len_s = 4'd9; valc_mode_s = 2'd1; ok_s = (hb_s[0][3:0] <= 4'h6);
            end
            4'h8: begin
                len_s = 4'd9; valc_mode_s = 2'd1; ok_s = (hb_s[0][3:0] == 4'h0);
            end
            4'h3, 4'h4, 4'h5: begin
                len_s = 4'd10; regs_s = 1'b1; valc_mode_s = 2'd2;
                ok_s = (hb_s[0][3:0] == 4'h0);
            end
            default: begin
                ok_s = 1'b0;
            end
        endcase
        if (!ok_s) begin
            len_s = 4'd1; regs_s = 1'b0; valc_mode_s = 2'd0;
        end else begin
            len_s = len_s;
        end
    end

    // Little-endian constant, status classification and the output handshake.
    always_comb begin
        valc_s    = 64'd0;
        err_hit_s = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (valc_mode_s == 2'd1) begin
                valc_s[8*j +: 8] = hb_s[j+1];
            end else if (valc_mode_s == 2'd2) begin
                valc_s[8*j +: 8] = hb_s[j+2];
            end else begin
                valc_s[8*j +: 8] = 8'h00;
            end
        end
        // Only bytes that are both queued and part of this instruction can fault it.
        for (int i = 0; i < 10; i++) begin
            if ((CW'(i) < count_r) && (4'(i) < len_s) && he_s[i]) begin
                err_hit_s = 1'b1;
            end else begin
                err_hit_s = err_hit_s;
            end
        end
        have_s       = (count_r != {CW{1'b0}});
        head_ready_s = 1'b0;
        stat_s       = STAT_AOK;
        if (!have_s) begin
            head_ready_s = 1'b0;
        end else if (!ok_s) begin
            head_ready_s = 1'b1; stat_s = STAT_INS;
        end else if (err_hit_s) begin
            head_ready_s = 1'b1; stat_s = STAT_ADR;
        end else if (count_r >= CW'(len_s)) begin
            head_ready_s = 1'b1;
            stat_s       = (hb_s[0][7:4] == 4'h0) ? STAT_HLT : STAT_AOK;
        end else begin
            head_ready_s = 1'b0;
        end
        out_valid_s = head_ready_s && (state_r == ST_RUN);
        in_ready_s  = (state_r == ST_RUN) &&
                      ((CW'(BUF_BYTES) - count_r) >= CW'(BYTES_PER_BEAT));
        push_s      = bus.in_valid && in_ready_s;
        pop_s       = out_valid_s && bus.out_ready;
        valp_s      = have_s ? (pc_r + PC_W'(len_s)) : pc_r;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.icode     = have_s ? hb_s[0][7:4] : 4'h0;
    assign bus.ifun      = have_s ? hb_s[0][3:0] : 4'h0;
    assign bus.rA        = (have_s && regs_s) ? hb_s[1][7:4] : 4'hF;
    assign bus.rB        = (have_s && regs_s) ? hb_s[1][3:0] : 4'hF;
    assign bus.valC      = have_s ? valc_s : 64'd0;
    assign bus.pc        = pc_r;
    assign bus.valP      = valp_s;
    assign bus.stat      = stat_s;
    assign bus.set_cc    = out_valid_s && (hb_s[0][7:4] == 4'h6) && (stat_s == STAT_AOK);
    assign bus.alufun    = (have_s && ok_s && (hb_s[0][7:4] == 4'h6)) ? hb_s[0][3:0] : 4'h0;

    // Queue pointers, byte storage, PC and run/stop state; redirect overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_BYTES; i++) begin
                mem_r[i] <= 8'h00;
            end
            err_r   <= {BUF_BYTES{1'b0}};
            rd_r    <= {AW{1'b0}};
            wr_r    <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            pc_r    <= {PC_W{1'b0}};
            state_r <= ST_RUN;
        end else if (bus.redirect) begin
            rd_r    <= {AW{1'b0}};
            wr_r    <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            pc_r    <= bus.redirect_pc;
            state_r <= ST_RUN;
        end else begin
            if (push_s) begin
                for (int i = 0; i < BYTES_PER_BEAT; i++) begin
                    mem_r[wr_r + AW'(i)] <= bus.in_data[8*i +: 8];
                    err_r[wr_r + AW'(i)] <= bus.in_err;
                end
                wr_r <= wr_r + AW'(BYTES_PER_BEAT);
            end
            if (pop_s) begin
                rd_r <= rd_r + AW'(len_s);
                pc_r <= valp_s;
                if (stat_s != STAT_AOK) begin
                    state_r <= ST_STOP;
                end
            end
            count_r <= count_r
                     + (push_s ? CW'(BYTES_PER_BEAT) : {CW{1'b0}})
                     - (pop_s  ? CW'(len_s)          : {CW{1'b0}});
        end
    end
endmodule

// File: tb/tb_y86_fetch_decode_queue.sv
// Scoreboard bench for the Y86-64 fetch/decode queue: expected instructions are queued
// as beats are driven and compared whenever the DUT completes a handshake.
module tb_y86_fetch_decode_queue;
    localparam int BPB = 8;
    localparam int BUF = 32;
    localparam int PCW = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    y86_fetch_decode_queue_if #(.BYTES_PER_BEAT(BPB), .PC_W(PCW)) bus ();

    y86_fetch_decode_queue #(.BYTES_PER_BEAT(BPB), .BUF_BYTES(BUF), .PC_W(PCW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] pc;
        logic [63:0] valp;
        logic [1:0]  stat;
        logic        set_cc;
        logic [3:0]  alufun;
        bit          full;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                                input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] pc,
                                input logic [63:0] vp, input logic [1:0] st, input bit full = 1'b1);
        exp_t e;
        e.icode  = ic;  e.ifun = fn;  e.ra = ra;  e.rb = rb;
        e.valc   = vc;  e.pc   = pc;  e.valp = vp; e.stat = st;
        e.set_cc = (ic == 4'h6) && (st == 2'b00);
        e.alufun = (ic == 4'h6) ? fn : 4'h0;
        e.full   = full;
        return e;
    endfunction

    // Compare every completed handshake with the oldest expected instruction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("icode", {60'd0, bus.icode}, {60'd0, e.icode});
                check_eq("ifun",  {60'd0, bus.ifun},  {60'd0, e.ifun});
                check_eq("pc",    bus.pc,             e.pc);
                check_eq("valP",  bus.valP,           e.valp);
                check_eq("stat",  {62'd0, bus.stat},  {62'd0, e.stat});
                if (e.full) begin
                    check_eq("rA",     {60'd0, bus.rA},     {60'd0, e.ra});
                    check_eq("rB",     {60'd0, bus.rB},     {60'd0, e.rb});
                    check_eq("valC",   bus.valC,            e.valc);
                    check_eq("set_cc", {63'd0, bus.set_cc}, {63'd0, e.set_cc});
                    check_eq("alufun", {60'd0, bus.alufun}, {60'd0, e.alufun});
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic err);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_err = err;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0; bus.in_err = 1'b0;
                return;
            end
        end
        check_eq("beat_accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b0; bus.in_err = 1'b0;
    endtask

    task automatic redirect_to(input logic [63:0] a);
        @(posedge clk); #1;
        bus.redirect = 1'b1; bus.redirect_pc = a;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check_eq(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.in_err = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 64'd0; bus.out_ready = 1'b0;

        // Reset values
        #2;
        check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check_eq("rst_icode",     {60'd0, bus.icode},     64'd0);
        check_eq("rst_rA",        {60'd0, bus.rA},        64'hF);
        check_eq("rst_rB",        {60'd0, bus.rB},        64'hF);
        check_eq("rst_valC",      bus.valC,               64'd0);
        check_eq("rst_pc",        bus.pc,                 64'd0);
        check_eq("rst_valP",      bus.valP,               64'd0);
        check_eq("rst_stat",      {62'd0, bus.stat},      64'd0);
        check_eq("rst_set_cc",    {63'd0, bus.set_cc},    64'd0);
        #5 rst_n = 1'b1;

        // irmovq $10,%rbx ; addq %rax,%rbx ; halt
        bus.out_ready = 1'b1;
        sb_q.push_back(mk(4'h3, 4'h0, 4'hF, 4'h3, 64'd10, 64'd0,  64'd10, 2'b00));
        sb_q.push_back(mk(4'h6, 4'h0, 4'h0, 4'h3, 64'd0,  64'd10, 64'd12, 2'b00));
        sb_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0,  64'd12, 64'd13, 2'b01));
        send_beat(64'h0000_0000_000A_F330, 1'b0);
        send_beat(64'h0000_0000_0360_0000, 1'b0);
        wait_drain("basic_drain");
        @(negedge clk);
        check_eq("hlt_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check_eq("hlt_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Invalid head byte, then redirect out of STOP
        redirect_to(64'h40);
        @(negedge clk);
        check_eq("redir40_pc",       bus.pc,                64'h40);
        check_eq("redir40_in_ready", {63'd0, bus.in_ready}, 64'd1);
        sb_q.push_back(mk(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h40, 64'h41, 2'b11));
        send_beat(64'h0000_0000_0000_00C0, 1'b0);
        wait_drain("ins_drain");
        @(negedge clk);
        check_eq("ins_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check_eq("ins_out_valid", {63'd0, bus.out_valid}, 64'd0);
        redirect_to(64'h100);
        @(negedge clk);
        check_eq("redir_pc",        bus.pc,                 64'h100);
        check_eq("redir_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check_eq("redir_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // 10-byte irmovq split across two beats
        sb_q.push_back(mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0807_0605_0403_0201, 64'h100, 64'h10A, 2'b00));
        sb_q.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h10A, 64'h10B, 2'b00));
        sb_q.push_back(mk(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h10B, 64'h10C, 2'b01));
        send_beat(64'h0605_0403_0201_F330, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("split_wait_out_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        send_beat(64'h0000_0000_0010_0807, 1'b0);
        @(negedge clk);
        check_eq("split_latency_out_valid", {63'd0, bus.out_valid}, 64'd1);
        wait_drain("split_drain");

        // Clean addq and nops, then a jmp whose last constant byte is error-flagged
        redirect_to(64'h200);
        sb_q.push_back(mk(4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'h200, 64'h202, 2'b00));
        for (int k = 0; k < 6; k++) begin
            sb_q.push_back(mk(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h202 + 64'(k), 64'h203 + 64'(k), 2'b00));
        end
        sb_q.push_back(mk(4'h7, 4'h0, 4'hF, 4'hF, 64'd0, 64'h208, 64'h211, 2'b10, 1'b0));
        send_beat(64'h1010_1010_1010_1260, 1'b0);
        send_beat(64'h7766_5544_3322_1170, 1'b0);
        repeat (10) @(negedge clk);
        check_eq("adr_pending_sb",        64'(sb_q.size()),       64'd1);
        check_eq("adr_pending_out_valid", {63'd0, bus.out_valid}, 64'd0);
        send_beat(64'h0000_0000_0000_0088, 1'b1);
        wait_drain("adr_drain");
        @(negedge clk);
        check_eq("adr_in_ready", {63'd0, bus.in_ready}, 64'd0);

        // Fill the queue, then push and pop together across the pointer wrap
        bus.out_ready = 1'b0;
        redirect_to(64'h0);
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                sb_q.push_back(mk(4'h6, 4'h0, 4'(2*k), 4'(2*k+1), 64'd0,
                                  64'(8*b + 2*k), 64'(8*b + 2*k + 2), 2'b00));
            end
        end
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(mk(4'h6, 4'(k), 4'(8 + 2*k), 4'(9 + 2*k), 64'd0,
                              64'(32 + 2*k), 64'(34 + 2*k), 2'b00));
        end
        for (int b = 0; b < 3; b++) send_beat(64'h6760_4560_2360_0160, 1'b0);
        @(negedge clk);
        check_eq("fill24_in_ready", {63'd0, bus.in_ready}, 64'd1);
        send_beat(64'h6760_4560_2360_0160, 1'b0);
        @(negedge clk);
        check_eq("fill32_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check_eq("fill32_out_valid", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b1; bus.in_data = 64'hEF63_CD62_AB61_8960;
        @(negedge clk);
        check_eq("wrap_in_ready_before", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq("wrap_in_ready_after", {63'd0, bus.in_ready}, 64'd0);
        check_eq("wrap_sb_remaining",   64'(sb_q.size()),      64'd15);
        bus.out_ready = 1'b1;
        wait_drain("wrap_drain");
        @(negedge clk);
        check_eq("wrap_empty_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("wrap_empty_in_ready",  {63'd0, bus.in_ready},  64'd1);

        // valP wrap at the top of the address space, then asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        redirect_to(64'hFFFF_FFFF_FFFF_FFFF);
        send_beat(64'h1010_1010_1010_1010, 1'b0);
        @(negedge clk);
        check_eq("wrap_pc_out_valid", {63'd0, bus.out_valid}, 64'd1);
        check_eq("wrap_pc_pc",        bus.pc,                 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("wrap_pc_valP",      bus.valP,               64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("async_rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check_eq("async_rst_pc",        bus.pc,                 64'd0);
        check_eq("async_rst_rA",        {60'd0, bus.rA},        64'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
